sccb_target: RTL and testbench

//  SCCB/I2C-style responder on a 2-wire bus: byte-addressed 256x8 register file, OV7670-compatible.

---
 rtl/sccb_pkg.sv | 20 ++
 rtl/sccb_line_sync.sv | 48 ++++
 rtl/sccb_target.sv | 213 +++++++++++++++++++++
 tb/tb_sccb_target.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target responder.
package sccb_pkg;

  localparam logic [6:0] SCCB_OV7670_ID = 7'h21;
  localparam logic       SCCB_RW_READ   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_WAIT_STOP
  } sccb_tgt_state_t;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronises the asynchronous scl/sda lines into clk and derives one-cycle
// scl edge and START/STOP condition pulses.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // An idle bus floats high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder with a 256x8 register file: 3-phase writes, 2-phase reads,
// host read port and a write-event strobe.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = SCCB_OV7670_ID,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_INIT    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] reg_rd_addr,
  output logic [7:0] reg_rd_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk        (clk),
    .reset      (reset),
    .i_scl      (scl),
    .i_sda      (sda_in),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  sccb_tgt_state_t r_state;
  logic [3:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_sub_addr;
  logic            r_sda_oe;
  logic            r_wr_strobe;
  logic [7:0]      r_wr_addr;
  logic [7:0]      r_wr_data;
  logic            r_busy;

  // Register file: array without reset plus per-entry valid bits, so the
  // storage still maps to block RAM while reset restores REG_INIT everywhere.
  logic [7:0]   r_mem [256];
  logic [255:0] r_valid;
  logic [7:0]   r_host_q;
  logic         r_host_vld;
  logic [7:0]   r_bus_q;
  logic         r_bus_vld;
  logic         w_host_hit;
  logic [7:0]   w_bus_byte;

  always_ff @(posedge clk) begin
    if (r_wr_strobe) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

  assign w_host_hit = r_wr_strobe && (r_wr_addr == reg_rd_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_host_q   <= 8'h00;
      r_host_vld <= 1'b0;
      r_bus_q    <= 8'h00;
      r_bus_vld  <= 1'b0;
    end else begin
      if (r_wr_strobe) begin
        r_valid[r_wr_addr] <= 1'b1;
      end
      if (w_host_hit) begin
        r_host_q   <= r_wr_data;
        r_host_vld <= 1'b1;
      end else begin
        r_host_q   <= r_mem[reg_rd_addr];
        r_host_vld <= r_valid[reg_rd_addr];
      end
      r_bus_q   <= r_mem[r_sub_addr];
      r_bus_vld <= r_valid[r_sub_addr];
    end
  end

  assign reg_rd_data = r_host_vld ? r_host_q : REG_INIT;
  assign w_bus_byte  = r_bus_vld ? r_bus_q : REG_INIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'h00;
      r_sub_addr  <= 8'h00;
      r_sda_oe    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        r_state   <= ST_ID;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else begin
        case (r_state)
          ST_ID, ST_SUB, ST_WDATA: begin
            if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ID) begin
                if (r_shift[7:1] == DEV_ADDR) begin
                  r_sda_oe <= 1'b1;
                  r_state  <= ST_ID_ACK;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end else if (r_state == ST_SUB) begin
                r_sda_oe   <= 1'b1;
                r_sub_addr <= r_shift;
                r_state    <= ST_SUB_ACK;
              end else begin
                r_sda_oe    <= 1'b1;
                r_wr_strobe <= 1'b1;
                r_wr_addr   <= r_sub_addr;
                r_wr_data   <= r_shift;
                r_sub_addr  <= r_sub_addr + 8'd1;
                r_state     <= ST_WDATA_ACK;
              end
            end
          end
          ST_ID_ACK: begin
            if (w_scl_fall) begin
              if (r_shift[0] == SCCB_RW_READ) begin
                // The ack-ending fall doubles as the drive edge for read bit 7.
                r_sda_oe  <= ~w_bus_byte[7];
                r_shift   <= {w_bus_byte[6:0], 1'b0};
                r_bit_cnt <= 4'd0;
                r_state   <= ST_RD;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_SUB;
              end
            end
          end
          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= ST_WDATA;
            end
          end
          ST_RD: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            // r_bit_cnt==1 marks "master acked, next byte pending".
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_sub_addr <= r_sub_addr + 8'd1;
                r_bit_cnt  <= 4'd1;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end else if (w_scl_fall && (r_bit_cnt == 4'd1)) begin
              r_sda_oe  <= ~w_bus_byte[7];
              r_shift   <= {w_bus_byte[6:0], 1'b0};
              r_bit_cnt <= 4'd0;
              r_state   <= ST_RD;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator with a byte-array model of
// the register file and sub-address pointer.
`timescale 1ns/1ps
module tb_sccb_target;

  localparam int TQ = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_strobe;
  logic       busy;
  logic [7:0] reg_rd_addr = 8'h00;
  logic [7:0] reg_rd_data;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int checks = 0;
  int failures = 0;
  int oe_cnt = 0;
  logic [15:0] obs_q[$];
  logic [7:0]  m_regs [256];
  logic [7:0]  m_sub;

  // Open-drain bus: either side can pull the line low.
  assign sda_in = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  sccb_target #(
    .DEV_ADDR    (7'h21),
    .SYNC_STAGES (2),
    .REG_INIT    (8'h00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scl         (scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; #TQ;
    scl = 1'b1;   #TQ;
    m_sda = 1'b0; #TQ;
    scl = 1'b0;   #TQ;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #TQ;
    scl = 1'b1;   #TQ;
    m_sda = 1'b1; #(2*TQ);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; #TQ;
      scl = 1'b1;   #(2*TQ);
      scl = 1'b0;   #TQ;
    end
  endtask

  // Ninth clock: master drives m_bit, returns the line and sda_oe mid-high.
  task automatic ack_phase(input logic m_bit, output logic line, output logic oe);
    m_sda = m_bit; #TQ;
    scl = 1'b1;    #TQ;
    line = sda_in;
    oe = sda_oe;   #TQ;
    scl = 1'b0;    #TQ;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic line, oe;
    send_bits(b, 8);
    ack_phase(1'b1, line, oe);
    acked = (line == 1'b0) && oe;
  endtask

  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; #TQ;
      scl = 1'b1;   #TQ;
      b[i] = sda_in; #TQ;
      scl = 1'b0;   #TQ;
    end
  endtask

  task automatic host_check(input logic [7:0] a);
    @(negedge clk) reg_rd_addr = a;
    @(negedge clk);
    check_eq("host_rd", 32'(reg_rd_data), 32'(m_regs[a]));
    $display("TXN host_read addr=%02h data=%02h", a, reg_rd_data);
  endtask

  task automatic tx_write(input logic [6:0] id, input logic [7:0] addr, input int n, input logic [31:0] data);
    logic ok, match;
    logic [7:0] a, d;
    int q0, oe0;
    logic [15:0] exp_s [4];
    q0 = obs_q.size();
    oe0 = oe_cnt;
    match = (id == 7'h21);
    bus_start();
    check_eq("busy_start", 32'(busy), 32'd1);
    write_byte({id, 1'b0}, ok);
    check_eq("id_ack", 32'(ok), 32'(match));
    write_byte(addr, ok);
    check_eq("sub_ack", 32'(ok), 32'(match));
    for (int i = 0; i < n; i++) begin
      d = data[31-8*i -: 8];
      a = addr + 8'(i);
      write_byte(d, ok);
      check_eq("data_ack", 32'(ok), 32'(match));
      exp_s[i] = {a, d};
      if (match) m_regs[a] = d;
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check_eq("busy_stop", 32'(busy), 32'd0);
    check_eq("strobe_cnt", 32'(obs_q.size() - q0), match ? 32'(n) : 32'd0);
    if (match) begin
      m_sub = addr + 8'(n);
      for (int i = 0; i < n; i++)
        if (q0 + i < obs_q.size()) check_eq("strobe_addr_data", 32'(obs_q[q0+i]), 32'(exp_s[i]));
    end else begin
      check_eq("oe_quiet", 32'(oe_cnt - oe0), 32'd0);
    end
    $display("TXN write id=%02h sub=%02h n=%0d data=%08h", id, addr, n, data);
  endtask

  task automatic tx_read(input logic set_addr, input logic [7:0] addr, input int n);
    logic ok, line, oe, last;
    logic [7:0] b;
    if (set_addr) begin
      bus_start();
      write_byte(8'h42, ok);
      check_eq("rd_wid_ack", 32'(ok), 32'd1);
      write_byte(addr, ok);
      check_eq("rd_sub_ack", 32'(ok), 32'd1);
      bus_stop();
      m_sub = addr;
    end
    bus_start();
    write_byte(8'h43, ok);
    check_eq("rd_id_ack", 32'(ok), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b);
      check_eq("rd_data", 32'(b), 32'(m_regs[m_sub]));
      $display("TXN read sub=%02h data=%02h", m_sub, b);
      last = (i == n - 1);
      ack_phase(last, line, oe);
      check_eq("rd_master_ack_oe", 32'(oe), 32'd0);
      if (!last) m_sub = m_sub + 8'd1;
    end
    bus_stop();
    repeat (4) @(negedge clk);
    check_eq("rd_oe_after_stop", 32'(sda_oe), 32'd0);
    check_eq("rd_busy_after_stop", 32'(busy), 32'd0);
  endtask

  initial begin
    logic ok, line, oe;
    logic [7:0] b;
    int q0;
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_sub = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    host_check(8'h00);

    // Single write, then rejected ID, then readback
    tx_write(7'h21, 8'h12, 1, 32'h80000000);
    check_eq("wr_addr_last", 32'(wr_addr), 32'h12);
    check_eq("wr_data_last", 32'(wr_data), 32'h80);
    host_check(8'h12);
    tx_write(7'h30, 8'h12, 1, 32'h55000000);
    host_check(8'h12);
    tx_read(1'b1, 8'h12, 1);

    // Burst across the 0xFF -> 0x00 wrap
    tx_write(7'h21, 8'hFE, 3, 32'hAABBCC00);
    host_check(8'hFE);
    host_check(8'hFF);
    host_check(8'h00);

    // Repeated START four bits into a data byte
    tx_write(7'h21, 8'h10, 1, 32'h3C000000);
    bus_start();
    write_byte(8'h42, ok);
    check_eq("rs_id_ack", 32'(ok), 32'd1);
    write_byte(8'h10, ok);
    check_eq("rs_sub_ack", 32'(ok), 32'd1);
    m_sub = 8'h10;
    q0 = obs_q.size();
    send_bits(8'hA5, 4);
    bus_start();
    write_byte(8'h43, ok);
    check_eq("rs_rd_ack", 32'(ok), 32'd1);
    read_byte(b);
    check_eq("rs_rd_data", 32'(b), 32'(m_regs[8'h10]));
    ack_phase(1'b1, line, oe);
    bus_stop();
    repeat (4) @(negedge clk);
    check_eq("rs_no_strobe", 32'(obs_q.size() - q0), 32'd0);
    host_check(8'h10);
    $display("TXN repeated_start_abort sub=10 read=%02h", b);

    // Reset while the target is driving the ID ack
    bus_start();
    send_bits(8'h42, 8);
    m_sda = 1'b1; #TQ;
    scl = 1'b1;   #TQ;
    check_eq("ack_before_reset", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("reset_sda_oe", 32'(sda_oe), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    #TQ;
    scl = 1'b0;
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    m_sub = 8'h00;
    #TQ;
    bus_stop();
    $display("TXN reset_during_ack");
    tx_write(7'h21, 8'h05, 1, 32'h11000000);
    host_check(8'h05);
    host_check(8'h12);

    // Randomised writes, reads and host reads against the model
    for (int it = 0; it < 8; it++) begin
      logic [6:0] id;
      logic [7:0] a;
      int n;
      id = 7'h21;
      if ($urandom_range(0, 3) == 0) begin
        id = 7'($urandom_range(0, 127));
        if (id == 7'h21) id = 7'h22;
      end
      a = 8'($urandom);
      n = $urandom_range(1, 4);
      tx_write(id, a, n, $urandom);
      tx_read(1'b1, a, $urandom_range(1, 4));
      host_check(a);
      host_check(8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
